// File: rtl/kf8253_pkg.sv
// Shared types and constants for the KF8253 access sequencer.
// The control-word helper packs {channel, read/write mode, counter mode, BCD} as the 8253 expects.
package kf8253_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_ACC2,
    ST_DONE
  } state_e;

  typedef enum logic {
    PH_ACTIVE,
    PH_RECOVER
  } phase_e;

  localparam logic [1:0] PIT_CTRL_ADDR = 2'd3;
  localparam logic [1:0] RW_LSB_MSB    = 2'b11;
  localparam logic [1:0] RW_LATCH      = 2'b00;

  function automatic logic [7:0] ctrl_word(input logic [1:0] ch, input logic [1:0] rw,
                                           input logic [2:0] mode, input logic bcd);
    return {ch, rw, mode, bcd};
  endfunction

endpackage

// File: rtl/kf8253_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping modulo NUM_REQ.
module kf8253_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kf8253_access_sequencer.sv
// Serialises whole program/readback operations from NUM_REQ requesters onto the KF8253 bus port.
// Bus outputs lag the state register by one clock, so every strobe and address is a clean flop output.
module kf8253_access_sequencer
  import kf8253_pkg::*;
#(
  parameter int NUM_REQ         = 3,
  parameter int STROBE_CYCLES   = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_read,
  input  logic [2*NUM_REQ-1:0]    req_channel,
  input  logic [3*NUM_REQ-1:0]    req_mode,
  input  logic [NUM_REQ-1:0]      req_bcd,
  input  logic [16*NUM_REQ-1:0]   req_count,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_error,
  output logic [15:0]             rsp_count,
  output logic                    busy,
  output logic                    pit_chip_select_n,
  output logic                    pit_read_enable_n,
  output logic                    pit_write_enable_n,
  output logic [1:0]              pit_address,
  output logic [7:0]              pit_data_out,
  input  logic [7:0]              pit_data_in
);

  localparam int         IDX_W  = $clog2(NUM_REQ);
  localparam logic [7:0] S_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] R_LAST = 8'(RECOVERY_CYCLES - 1);

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic               rd_q, rd_d, err_q, err_d, bcd_q, bcd_d;
  logic [1:0]         ch_q, ch_d;
  logic [2:0]         mode_q, mode_d;
  logic [15:0]        count_q, count_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic               rsp_error_q, rsp_error_d, busy_q, busy_d;
  logic [15:0]        rsp_count_q, rsp_count_d;
  logic               cs_n_q, cs_n_d, re_n_q, re_n_d, we_n_q, we_n_d;
  logic [1:0]         addr_q, addr_d;
  logic [7:0]         dout_q, dout_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [1:0]         gnt_ch;
  logic               in_acc, strobing;

  kf8253_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign gnt_ch   = req_channel[2*arb_idx +: 2];
  assign in_acc   = (state_q == ST_ACC0) || (state_q == ST_ACC1) || (state_q == ST_ACC2);
  assign strobing = in_acc && (phase_q == PH_ACTIVE);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    err_d       = err_q;
    ch_d        = ch_q;
    mode_d      = mode_q;
    bcd_d       = bcd_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_error_d = 1'b0;
    rsp_count_d = rsp_count_q;
    addr_d      = addr_q;
    dout_d      = dout_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_d = arb_grant;
          ptr_d       = arb_idx;
          idx_d       = arb_idx;
          rd_d        = req_read[arb_idx];
          ch_d        = gnt_ch;
          mode_d      = req_mode[3*arb_idx +: 3];
          bcd_d       = req_bcd[arb_idx];
          count_d     = req_count[16*arb_idx +: 16];
          err_d       = (gnt_ch == 2'd3);
          rdata_d     = '0;
          state_d     = (gnt_ch == 2'd3) ? ST_DONE : ST_ACC0;
          phase_d     = PH_ACTIVE;
          cnt_d       = '0;
        end
      end
      ST_ACC0, ST_ACC1, ST_ACC2: begin
        if (phase_q == PH_ACTIVE) begin
          if (cnt_q == S_LAST) begin
            phase_d = PH_RECOVER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          // First RECOVER state cycle is the last bus-ACTIVE cycle, so read data is valid now
          if (cnt_q == '0 && rd_q && state_q == ST_ACC1) rdata_d[7:0]  = pit_data_in;
          if (cnt_q == '0 && rd_q && state_q == ST_ACC2) rdata_d[15:8] = pit_data_in;
          if (cnt_q == R_LAST) begin
            phase_d = PH_ACTIVE;
            cnt_d   = '0;
            case (state_q)
              ST_ACC0: state_d = ST_ACC1;
              ST_ACC1: state_d = ST_ACC2;
              default: state_d = ST_DONE;
            endcase
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        rsp_valid_d[idx_q] = 1'b1;
        rsp_error_d        = err_q;
        rsp_count_d        = (rd_q && !err_q) ? rdata_q : 16'h0000;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cs_n_d = !strobing;
    we_n_d = !(strobing && (state_q == ST_ACC0 || !rd_q));
    re_n_d = !(strobing && state_q != ST_ACC0 && rd_q);
    if (in_acc) begin
      case (state_q)
        ST_ACC0: begin
          addr_d = PIT_CTRL_ADDR;
          dout_d = rd_q ? ctrl_word(ch_q, RW_LATCH, 3'd0, 1'b0)
                        : ctrl_word(ch_q, RW_LSB_MSB, mode_q, bcd_q);
        end
        ST_ACC1: begin
          addr_d = ch_q;
          dout_d = rd_q ? 8'h00 : count_q[7:0];
        end
        default: begin
          addr_d = ch_q;
          dout_d = rd_q ? 8'h00 : count_q[15:8];
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_ACTIVE;
      cnt_q       <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      idx_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      rsp_count_q <= '0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      re_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      addr_q      <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_count_q <= rsp_count_d;
      busy_q      <= busy_d;
      cs_n_q      <= cs_n_d;
      re_n_q      <= re_n_d;
      we_n_q      <= we_n_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
    end
  end

  // Captured operation payload; only meaningful after a grant, so it needs no reset
  always_ff @(posedge clock) begin
    rd_q    <= rd_d;
    err_q   <= err_d;
    ch_q    <= ch_d;
    mode_q  <= mode_d;
    bcd_q   <= bcd_d;
    count_q <= count_d;
    rdata_q <= rdata_d;
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_error          = rsp_error_q;
  assign rsp_count          = rsp_count_q;
  assign busy               = busy_q;
  assign pit_chip_select_n  = cs_n_q;
  assign pit_read_enable_n  = re_n_q;
  assign pit_write_enable_n = we_n_q;
  assign pit_address        = addr_q;
  assign pit_data_out       = dout_q;

endmodule

// File: tb/tb_kf8253_access_sequencer.sv
// Scoreboard bench for kf8253_access_sequencer: stimulus pushes expected grants, bus accesses and
// responses; one monitor process on the falling edge pops and compares whatever the DUT presents.
module tb_kf8253_access_sequencer;

  localparam int N = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_read = '0;
  logic [2*N-1:0]    req_channel = '0;
  logic [3*N-1:0]    req_mode = '0;
  logic [N-1:0]      req_bcd = '0;
  logic [16*N-1:0]   req_count = '0;
  logic [N-1:0]      rsp_valid;
  logic              rsp_error;
  logic [15:0]       rsp_count;
  logic              busy;
  logic              pit_chip_select_n, pit_read_enable_n, pit_write_enable_n;
  logic [1:0]        pit_address;
  logic [7:0]        pit_data_out;
  logic [7:0]        pit_data_in;

  kf8253_access_sequencer #(.NUM_REQ(N), .STROBE_CYCLES(2), .RECOVERY_CYCLES(1)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_read           (req_read),
    .req_channel        (req_channel),
    .req_mode           (req_mode),
    .req_bcd            (req_bcd),
    .req_count          (req_count),
    .rsp_valid          (rsp_valid),
    .rsp_error          (rsp_error),
    .rsp_count          (rsp_count),
    .busy               (busy),
    .pit_chip_select_n  (pit_chip_select_n),
    .pit_read_enable_n  (pit_read_enable_n),
    .pit_write_enable_n (pit_write_enable_n),
    .pit_address        (pit_address),
    .pit_data_out       (pit_data_out),
    .pit_data_in        (pit_data_in)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] data;
    logic       chk_gap;
  } bus_t;

  typedef struct {
    logic [N-1:0] oh;
    logic         err;
    logic         rd;
    logic [15:0]  cnt;
    int           lat;
  } rsp_t;

  bus_t         exp_bus[$];
  rsp_t         exp_rsp[$];
  logic [N-1:0] exp_gnt[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_gnt = 0, gnt_seen = 0, acc_started = 0;
  int rd_cnt = 0;
  logic [7:0] pit_lsb = 8'h00, pit_msb = 8'h00;

  // PIT model: first read after a control write returns the LSB, the next returns the MSB
  assign pit_data_in = (rd_cnt == 0) ? pit_lsb : pit_msb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic       in_acc, a_we;
    logic [1:0] a_addr;
    logic [7:0] a_data;
    int         lowcnt, gap, a_gap;
    bus_t       eb;
    rsp_t       er;
    in_acc = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0;
    lowcnt = 0; gap = 0; a_gap = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        in_acc = 1'b0;
        gap    = 0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cs_n", 32'(pit_chip_select_n), 32'd1);
      end else begin
        if (req_ready != '0) begin
          gnt_seen++;
          last_gnt = cyc;
          if (exp_gnt.size() == 0) chk("grant_unexpected", 32'(req_ready), 32'd0);
          else chk("grant", 32'(req_ready), 32'(exp_gnt.pop_front()));
          chk("busy_at_grant", 32'(busy), 32'd1);
        end
        if (rsp_valid != '0) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
          else begin
            er = exp_rsp.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(er.oh));
            chk("rsp_error", 32'(rsp_error), 32'(er.err));
            if (er.rd) chk("rsp_count", 32'(rsp_count), 32'(er.cnt));
            chk("rsp_latency", 32'(cyc - last_gnt), 32'(er.lat));
            chk("busy_at_rsp", 32'(busy), 32'd1);
          end
        end
        if (!pit_chip_select_n) begin
          if (!in_acc) begin
            in_acc = 1'b1;
            lowcnt = 0;
            a_we   = !pit_write_enable_n;
            a_addr = pit_address;
            a_data = pit_data_out;
            a_gap  = gap;
            acc_started++;
          end
          lowcnt++;
          chk("one_strobe_low", 32'(pit_write_enable_n ^ pit_read_enable_n), 32'd1);
          chk("acc_stable", 32'({pit_address, pit_data_out, !pit_write_enable_n}),
              32'({a_addr, a_data, a_we}));
        end else begin
          chk("strobes_high", 32'({pit_write_enable_n, pit_read_enable_n}), 32'd3);
          if (in_acc) begin
            in_acc = 1'b0;
            chk("recover_stable", 32'({pit_address, pit_data_out}), 32'({a_addr, a_data}));
            chk("strobe_len", 32'(lowcnt), 32'd2);
            if (exp_bus.size() == 0) chk("bus_unexpected", 32'(a_addr), 32'hFFFF);
            else begin
              eb = exp_bus.pop_front();
              chk("bus_is_read", 32'(!a_we), 32'(eb.rd));
              chk("bus_addr", 32'(a_addr), 32'(eb.addr));
              if (!eb.rd) chk("bus_wdata", 32'(a_data), 32'(eb.data));
              if (eb.chk_gap) chk("recover_len", 32'(a_gap), 32'd1);
            end
            if (a_we && a_addr == 2'd3) rd_cnt = 0;
            else if (!a_we) rd_cnt++;
            gap = 1;
          end else begin
            gap++;
          end
        end
      end
    end
  end

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic exp_prog(input int r, input logic [7:0] cw, input logic [1:0] ch,
                          input logic [7:0] lsb, input logic [7:0] msb);
    exp_gnt.push_back(onehot(r));
    exp_bus.push_back('{1'b0, 2'd3, cw, 1'b0});
    exp_bus.push_back('{1'b0, ch, lsb, 1'b1});
    exp_bus.push_back('{1'b0, ch, msb, 1'b1});
    exp_rsp.push_back('{onehot(r), 1'b0, 1'b0, 16'h0000, 10});
  endtask

  task automatic exp_read(input int r, input logic [7:0] cw, input logic [1:0] ch,
                          input logic [15:0] cnt);
    exp_gnt.push_back(onehot(r));
    exp_bus.push_back('{1'b0, 2'd3, cw, 1'b0});
    exp_bus.push_back('{1'b1, ch, 8'h00, 1'b1});
    exp_bus.push_back('{1'b1, ch, 8'h00, 1'b1});
    exp_rsp.push_back('{onehot(r), 1'b0, 1'b1, cnt, 10});
  endtask

  task automatic set_req(input int r, input logic rd, input logic [1:0] ch, input logic [2:0] mode,
                         input logic bcd, input logic [15:0] cnt);
    req_read[r]             = rd;
    req_channel[2*r +: 2]   = ch;
    req_mode[3*r +: 3]      = mode;
    req_bcd[r]              = bcd;
    req_count[16*r +: 16]   = cnt;
  endtask

  task automatic wait_grants(input int target);
    int k;
    for (k = 0; k < 200 && gnt_seen < target; k++) begin
      @(negedge clock);
      #1;
    end
    if (gnt_seen < target) chk("grant_timeout", 32'(gnt_seen), 32'(target));
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200 && (busy || exp_rsp.size() != 0); k++) begin
      @(negedge clock);
      #1;
    end
    if (busy || exp_rsp.size() != 0) chk("idle_timeout", 32'(exp_rsp.size()), 32'd0);
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic run_one(input int r);
    req_valid[r] = 1'b1;
    wait_grants(gnt_seen + 1);
    req_valid[r] = 1'b0;
    set_req(r, 1'b0, 2'd3, 3'd7, 1'b1, 16'hFFFF);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_strobes", 32'({pit_chip_select_n, pit_read_enable_n, pit_write_enable_n}), 32'd7);
    chk("reset_addr_data", 32'({pit_address, pit_data_out}), 32'd0);
    chk("reset_rsp", 32'({rsp_error, rsp_count}), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;

    // Program ch0 mode3 binary 0x1234 from req0
    set_req(0, 1'b0, 2'd0, 3'd3, 1'b0, 16'h1234);
    exp_prog(0, 8'h36, 2'd0, 8'h34, 8'h12);
    run_one(0);

    // Read ch2 from req1; PIT returns 0xCD then 0xAB
    pit_lsb = 8'hCD;
    pit_msb = 8'hAB;
    set_req(1, 1'b1, 2'd2, 3'd0, 1'b0, 16'h0000);
    exp_read(1, 8'h80, 2'd2, 16'hABCD);
    run_one(1);

    // Program ch1 mode2 BCD 0x0099 from req2
    set_req(2, 1'b0, 2'd1, 3'd2, 1'b1, 16'h0099);
    exp_prog(2, 8'h75, 2'd1, 8'h99, 8'h00);
    run_one(2);

    // Held contention: grants 0,1,2,0, then req1 drops and grants go 2,0,2
    set_req(0, 1'b0, 2'd0, 3'd3, 1'b0, 16'h1234);
    set_req(1, 1'b0, 2'd1, 3'd2, 1'b1, 16'h0099);
    set_req(2, 1'b0, 2'd2, 3'd0, 1'b0, 16'hBEEF);
    exp_prog(0, 8'h36, 2'd0, 8'h34, 8'h12);
    exp_prog(1, 8'h75, 2'd1, 8'h99, 8'h00);
    exp_prog(2, 8'hB0, 2'd2, 8'hEF, 8'hBE);
    exp_prog(0, 8'h36, 2'd0, 8'h34, 8'h12);
    exp_prog(2, 8'hB0, 2'd2, 8'hEF, 8'hBE);
    exp_prog(0, 8'h36, 2'd0, 8'h34, 8'h12);
    exp_prog(2, 8'hB0, 2'd2, 8'hEF, 8'hBE);
    base = gnt_seen;
    req_valid = 3'b111;
    wait_grants(base + 4);
    req_valid[1] = 1'b0;
    wait_grants(base + 7);
    req_valid = '0;
    wait_idle();

    // Illegal channel from req1: immediate error response, no bus activity
    set_req(1, 1'b0, 2'd3, 3'd0, 1'b0, 16'h5555);
    exp_gnt.push_back(onehot(1));
    exp_rsp.push_back('{onehot(1), 1'b1, 1'b0, 16'h0000, 1});
    run_one(1);

    // Reset during ACC1 ACTIVE of a req0 program; only the control write completes
    set_req(0, 1'b0, 2'd0, 3'd3, 1'b0, 16'h1234);
    exp_gnt.push_back(onehot(0));
    exp_bus.push_back('{1'b0, 2'd3, 8'h36, 1'b0});
    base = acc_started;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 100 && acc_started < base + 2; k++) begin
      @(negedge clock);
      #1;
    end
    chk("acc1_reached", 32'(acc_started), 32'(base + 2));
    req_valid[0] = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_cs_n", 32'(pit_chip_select_n), 32'd1);
    chk("async_we_n", 32'(pit_write_enable_n), 32'd1);
    chk("async_re_n", 32'(pit_read_enable_n), 32'd1);
    repeat (3) @(negedge clock);
    #1;
    reset_n = 1'b1;
    chk("dropped_op_bus", 32'(exp_bus.size()), 32'd0);

    // After reset the pointer restarts: req0 beats req1
    set_req(0, 1'b0, 2'd0, 3'd3, 1'b0, 16'h1234);
    set_req(1, 1'b0, 2'd1, 3'd2, 1'b1, 16'h0099);
    exp_prog(0, 8'h36, 2'd0, 8'h34, 8'h12);
    exp_prog(1, 8'h75, 2'd1, 8'h99, 8'h00);
    base = gnt_seen;
    req_valid = 3'b011;
    wait_grants(base + 1);
    req_valid[0] = 1'b0;
    wait_grants(base + 2);
    req_valid[1] = 1'b0;
    wait_idle();

    chk("left_grants", 32'(exp_gnt.size()), 32'd0);
    chk("left_bus", 32'(exp_bus.size()), 32'd0);
    chk("left_rsp", 32'(exp_rsp.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kf8253_access_sequencer.md
Name: kf8253_access_sequencer

Overview:
Sequences all CPU-independent programming and readback traffic into the KF8253 bus port on behalf of up to NUM_REQ on-chip requesters (e.g. refresh timer setup, speaker tone, tick readback). Each request is a whole operation: program channel (control word + LSB + MSB) or read channel (latch command + LSB read + MSB read). Requesters are served round-robin. The block drives the PIT chip-select, strobes, address and data with configurable strobe and recovery timing.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
STROBE_CYCLES, 2, clocks each access holds cs_n/strobe low (>=1)
RECOVERY_CYCLES, 1, clocks all strobes high after each access (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot, 1-cycle grant pulse; payload captured on this cycle
req_read  in  NUM_REQ  1 = readback operation, 0 = program operation
req_channel  in  2*NUM_REQ  target channel 0..2; 3 is illegal
req_mode  in  3*NUM_REQ  8253 mode 0..5 (program only)
req_bcd  in  NUM_REQ  BCD counting select (program only)
req_count  in  16*NUM_REQ  reload value (program only)
rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse to the granted requester
rsp_error  out  1  qualifies rsp_valid: illegal channel
rsp_count  out  16  readback value, valid with rsp_valid of a read
busy  out  1  high from grant until rsp_valid cycle inclusive
pit_chip_select_n  out  1  to KF8253 chip_select_n
pit_read_enable_n  out  1  to KF8253 read_enable_n
pit_write_enable_n  out  1  to KF8253 write_enable_n
pit_address  out  2  to KF8253 address
pit_data_out  out  8  to KF8253 data_bus_in
pit_data_in  in  8  from KF8253 data_bus_out

Behaviour:
- Reset (async assert, all outputs registered): FSM IDLE; req_ready=0, rsp_valid=0, rsp_error=0, rsp_count=0, busy=0, all pit_*_n=1, pit_address=0, pit_data_out=0; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: strobes deassert immediately on reset_n low; the operation is dropped with no rsp_valid.
- States: IDLE -> ACC0 -> ACC1 -> ACC2 -> DONE -> IDLE. ACCn has sub-phase ACTIVE (STROBE_CYCLES clocks) then RECOVER (RECOVERY_CYCLES clocks).
- IDLE: if any req_valid, grant the first set bit searching from pointer+1 modulo NUM_REQ. Pulse req_ready, capture payload, set pointer = granted index, go ACC0 (or DONE with error when channel==3; no bus activity).
- Program: ACC0 writes addr 3, data {ch,2'b11,mode,bcd}. ACC1 writes addr ch, data count[7:0]. ACC2 writes addr ch, data count[15:8].
- Read: ACC0 writes addr 3, data {ch,6'b0} (counter latch). ACC1 reads addr ch, giving LSB. ACC2 reads addr ch, giving MSB.
- ACTIVE: pit_chip_select_n=0, and pit_write_enable_n=0 or pit_read_enable_n=0, never both. Address and data are stable for the whole access, including RECOVER.
- Read data is sampled from pit_data_in on the last ACTIVE clock.
- RECOVER: all pit_*_n=1.
- DONE: rsp_valid[idx]=1 for one clock with rsp_error/rsp_count; busy falls the next clock. IDLE may grant again on the clock after DONE.
- Latency: grant at clock t, ACC0 starts t+1, rsp_valid at t+1+3*(STROBE_CYCLES+RECOVERY_CYCLES). With defaults, rsp_valid is at t+10.
- Payload changes after grant are ignored. Dropping req_valid before grant is legal: no grant, no side effects.
- Mode values 6/7 are passed through unchanged; the 8253 itself aliases them.

Decomposition:
- Package kf8253_pkg: FSM state enum; access sub-phase enum; PIT_CTRL_ADDR=2'd3; RW_LSB_MSB=2'b11; RW_LATCH=2'b00; a function building the control word from (ch, rw, mode, bcd).
- Sub-module kf8253_rr_arbiter (parameter NUM_REQ): req vector plus pointer in, one-hot grant and index out, purely combinational. The pointer register stays in the sequencer.

Test Plan:
- Program ch0 mode3 bcd0 count 0x1234 from req0. Expect bus sequence (addr3,0x36), (addr0,0x34), (addr0,0x12), each write strobe low for 2 clocks then high for 1. Expect rsp_valid[0] 10 clocks after req_ready[0] and rsp_error=0.
- Read ch2 with the PIT model returning 0xCD then 0xAB. Expect write (addr3,0x80), then two reads at addr2. Expect rsp_count=0xABCD and no write strobes during the reads.
- req0, req1, req2 asserted together and held. Expect grant order 0,1,2,0. Then with only req0 and req2 held, expect grants alternating 2,0,2.
- Program ch1 mode2 bcd1 count 0x0099. Expect control word 0x75, then LSB 0x99, then MSB 0x00.
- Request with channel 3. Expect rsp_valid with rsp_error=1 on the clock after the grant, and pit_chip_select_n held at 1 throughout.
- Assert reset_n low during ACC1 ACTIVE. Expect all pit_*_n=1 asynchronously and no rsp_valid. After release, expect IDLE with requester 0 winning the next contention.
